regbank_s8_arbiter: RTL and testbench
=====================================

// Module: regbank_s8_arbiter
// PURPOSE
//  Round-robin arbiter sharing one RegBankS8 instruction port among NREQ requesters.
//  Each requester submits a 12-bit RegBankS8 instruction (inst[11:8] opcode, inst[7:0] operand) via req/ack.
//  The arbiter issues one instruction at a time and returns RDO results to the owning requester.
//  It sits between client sequencers and a single RegBankS8 instance.
// PARAMETERS
//  NREQ        2  number of requesters (>=2)
//  IDXW        1  index width, clog2(NREQ)
//  RD_LATENCY  1  cycles from the RDO issue edge until rb_out holds the result (>=1)
// PORTS
//  clock       in   1          single clock; all state changes on the rising edge
//  reset       in   1          synchronous, active-low reset
//  req         in   NREQ       req[k]: requester k has an instruction pending
//  req_inst    in   12*NREQ    requester k instruction in bits [12k+11:12k]; held while req[k]=1
//  ack         out  NREQ       one-cycle completion pulse to the owner
//  err         out  1          with ack: instruction was rejected (illegal opcode)
//  rd_data     out  8          RDO result; valid only while ack=1 and the op was RDO
//  rb_inst     out  12         to RegBankS8 inst
//  rb_inst_en  out  1          to RegBankS8 inst_en
//  rb_out      in   8          from RegBankS8 out
//  busy        out  1          1 whenever state != IDLE
// BEHAVIOUR
//  Reset (reset=0 at a rising edge): state=IDLE, ack=0, err=0, rd_data=8'h00, rb_inst=12'h000,
//   rb_inst_en=0, busy=0, wait counter=0, last-grant pointer=NREQ-1 (requester 0 has top priority).
//   Reset overrides any state, mid-transaction included. The in-flight op is dropped without ack.
//  FSM states: IDLE, ISSUE, WAIT, DONE.
//  IDLE: if |req, pick the winner: first k with req[k]=1, scanning from last+1 and wrapping modulo NREQ.
//   Latch the winner's instruction and index, set last=winner, go ISSUE. If no req, stay IDLE.
//  ISSUE (1 cycle): legality check on the latched opcode.
//   Legal opcodes: `RegBankS8_NOP, `RegBankS8_LD0..`RegBankS8_LD7, `RegBankS8_RDO.
//   Legal op: rb_inst=latched inst, rb_inst_en=1.
//     RDO -> WAIT with counter=RD_LATENCY. Any other legal op -> DONE.
//   Illegal op: rb_inst_en stays 0 (never forwarded), set err flag, go DONE.
//  WAIT: rb_inst_en=0; decrement the counter each cycle.
//   In the cycle where counter==1, capture rb_out into rd_data at the edge and go DONE.
//   A read therefore spans RD_LATENCY WAIT cycles.
//  DONE (1 cycle): ack[owner]=1, err=flag, rd_data held; go IDLE.
//   err and rd_data clear on the following edge (rd_data returns to 8'h00).
//  Occupancy per op: IDLE+ISSUE+DONE = 3 cycles for non-reads; 3+RD_LATENCY cycles for RDO.
//   Grants are never back-to-back. IDLE always separates two transactions.
//  rb_inst_en is high for exactly one cycle per legal op and is 0 in IDLE, WAIT and DONE.
//   rb_inst keeps its last value while disabled.
//  Requester protocol: raise req[k], hold req_inst stable, drop req in the cycle after seeing ack[k].
//   If req[k] falls before ack, the latched op still completes and acks. req is not sampled after the grant.
//  Requests arriving or changing during ISSUE/WAIT/DONE have no effect until the next IDLE.
//  Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NREQ-1,0,...
//  ack is one-hot or zero. At most one transaction is in flight.
// TESTING
//  1. reset=0 for 2 cycles, then 1 -> ack=0, rb_inst_en=0, busy=0, rd_data=00. First grant with both req=1 goes to req 0.
//  2. req0: LD3,8'h5A -> rb_inst={LD3,5A} with rb_inst_en=1 one cycle after grant, ack[0] 2 cycles after grant, err=0.
//     Then req0: RDO,8'h03 -> ack[0] with rd_data=8'h5A, RD_LATENCY+2 cycles after grant.
//  3. req0 and req1 held high, each issuing LD0 with distinct data -> grants alternate 0,1,0,1.
//     ack never asserted on both. rb_inst_en pulses spaced 3 cycles apart.
//  4. req1 inst=12'hFAB (illegal opcode) -> rb_inst_en never asserts. ack[1]=1 with err=1, then err=0 next cycle.
//     Register contents are unchanged (verify with RDO).
//  5. reset=0 asserted during WAIT of an RDO -> next cycle state IDLE, no ack.
//     After release, the pending req is re-granted from requester 0 priority.
//  6. req0 pulsed for only the IDLE grant cycle with LD7,8'h61 -> the op still issues and ack[0] fires.
//     A subsequent RDO 7 returns 8'h61.

Source files
------------

// File: rtl/regbank_s8_arbiter.sv
// Round-robin arbiter that shares one RegBankS8 instruction port among NREQ
// requesters. One instruction is in flight at a time. RDO results are captured
// from the bank and returned to the requester that issued the read.

`ifndef RegBankS8_NOP
`define RegBankS8_NOP 4'h0
`endif
`ifndef RegBankS8_LD0
`define RegBankS8_LD0 4'h1
`endif
`ifndef RegBankS8_LD7
`define RegBankS8_LD7 4'h8
`endif
`ifndef RegBankS8_RDO
`define RegBankS8_RDO 4'h9
`endif

module regbank_s8_arbiter #(
  parameter int NREQ       = 2,
  parameter int IDXW       = 1,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [12*NREQ-1:0]   req_inst,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [7:0]           rd_data,
  output logic [11:0]          rb_inst,
  output logic                 rb_inst_en,
  input  logic [7:0]           rb_out,
  output logic                 busy
);

  localparam int CNTW = $clog2(RD_LATENCY + 1);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [IDXW-1:0]   last;
  logic [IDXW-1:0]   owner;
  logic [IDXW-1:0]   winner;
  logic [3:0]        op_q;
  logic              bad_q;
  logic [CNTW-1:0]   cnt;
  logic [11:0]       inst_arr [NREQ];
  logic [11:0]       winner_inst;
  logic              winner_legal;

  // NOP, LD0..LD7 and RDO are the only opcodes the bank understands.
  function automatic logic op_legal(input logic [3:0] op);
    return (op == `RegBankS8_NOP) ||
           ((op >= `RegBankS8_LD0) && (op <= `RegBankS8_LD7)) ||
           (op == `RegBankS8_RDO);
  endfunction

  // First requester after 'from', wrapping modulo NREQ.
  function automatic logic [IDXW-1:0] rr_pick(input logic [IDXW-1:0] from,
                                              input logic [NREQ-1:0] r);
    logic [IDXW-1:0] pick;
    logic            hit;
    int              idx;
    pick = from;
    hit  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(from) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && r[IDXW'(idx)]) begin
        pick = IDXW'(idx);
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign inst_arr[g] = req_inst[12*g +: 12];
  end

  assign winner       = rr_pick(last, req);
  assign winner_inst  = inst_arr[winner];
  assign winner_legal = op_legal(winner_inst[11:8]);

  // State register; reset abandons any in-flight op without an ack.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (|req) state_nx = ISSUE;
      ISSUE: begin
        if (bad_q)                          state_nx = DONE;
        else if (op_q == `RegBankS8_RDO)    state_nx = WAIT;
        else                                state_nx = DONE;
      end
      WAIT:  if (cnt == CNTW'(1)) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One-hot completion pulse to the owner during DONE.
  always_comb begin
    ack = '0;
    if (state == DONE) ack[owner] = 1'b1;
  end

  assign err        = (state == DONE) && bad_q;
  assign rb_inst_en = (state == ISSUE) && !bad_q;
  assign busy       = (state != IDLE);

  // Grant bookkeeping, bank command register, read wait counter and result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last    <= LAST_RST;
      rb_inst <= 12'h000;
      bad_q   <= 1'b0;
      cnt     <= '0;
      rd_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            last  <= winner;
            bad_q <= !winner_legal;
            // Illegal ops never reach the bank, so rb_inst keeps its old value.
            if (winner_legal) rb_inst <= winner_inst;
          end
        end
        ISSUE: begin
          if (!bad_q && (op_q == `RegBankS8_RDO)) cnt <= CNTW'(RD_LATENCY);
        end
        WAIT: begin
          cnt <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) rd_data <= rb_out;
        end
        DONE: begin
          rd_data <= 8'h00;
        end
        default: ;
      endcase
    end
  end

  // Winner index and opcode latched at grant; pure data, no reset needed.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && (|req)) begin
      owner <= winner;
      op_q  <= winner_inst[11:8];
    end
  end

endmodule

// File: tb/tb_regbank_s8_arbiter.sv
// Bench for regbank_s8_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model of the arbiter.

`ifndef RegBankS8_NOP
`define RegBankS8_NOP 4'h0
`endif
`ifndef RegBankS8_LD0
`define RegBankS8_LD0 4'h1
`endif
`ifndef RegBankS8_LD7
`define RegBankS8_LD7 4'h8
`endif
`ifndef RegBankS8_RDO
`define RegBankS8_RDO 4'h9
`endif

module tb_regbank_s8_arbiter;

  localparam int NREQ = 2;
  localparam int IDXW = 1;
  localparam int L    = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [12*NREQ-1:0]  req_inst = '0;
  logic [NREQ-1:0]     ack;
  logic                err;
  logic [7:0]          rd_data;
  logic [11:0]         rb_inst;
  logic                rb_inst_en;
  logic [7:0]          rb_out;
  logic                busy;

  regbank_s8_arbiter #(.NREQ(NREQ), .IDXW(IDXW), .RD_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .req(req), .req_inst(req_inst),
    .ack(ack), .err(err), .rd_data(rd_data), .rb_inst(rb_inst),
    .rb_inst_en(rb_inst_en), .rb_out(rb_out), .busy(busy)
  );

  always #5 clock = ~clock;

  // Stand-in RegBankS8: LDk writes register k, RDO result appears L edges later.
  logic [7:0]     bank [8] = '{default: 8'h00};
  logic [8*L-1:0] pipe = '0;
  logic [3:0]     bank_sel;
  logic [7:0]     pipe_in;
  assign bank_sel = rb_inst[11:8] - `RegBankS8_LD0;
  assign pipe_in  = (rb_inst_en && rb_inst[11:8] == `RegBankS8_RDO) ? bank[rb_inst[2:0]] : 8'h00;
  assign rb_out   = pipe[8*L-1 -: 8];

  // Bank model update on each rising edge.
  always @(posedge clock) begin
    if (rb_inst_en && rb_inst[11:8] >= `RegBankS8_LD0 && rb_inst[11:8] <= `RegBankS8_LD7)
      bank[bank_sel[2:0]] <= rb_inst[7:0];
    pipe <= (pipe << 8) | (8*L)'(pipe_in);
  end

  // Reference model state (transaction level: owner, position in the op, length).
  logic [7:0]  m_regs [8] = '{default: 8'h00};
  bit          m_active;
  int          m_t, m_len, m_owner, m_last;
  bit          m_legal, m_rdo;
  logic [7:0]  m_rdval;
  logic [11:0] m_rb_inst;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [NREQ-1:0] drop_pend = '0;
  logic [NREQ-1:0] ack_seen = '0;
  logic [7:0]  en_ops [$];
  int          en_cyc [$];
  logic [7:0]  last_rd = 8'h00;
  logic        last_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit legal_op(input logic [3:0] op);
    return (op == `RegBankS8_NOP) || (op >= `RegBankS8_LD0 && op <= `RegBankS8_LD7) ||
           (op == `RegBankS8_RDO);
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_t       = 0;
    m_len     = 0;
    m_last    = NREQ - 1;
    m_rb_inst = 12'h000;
  endtask

  // Advance the model across one rising edge using the request inputs at that edge.
  task automatic model_step();
    int w;
    logic [NREQ-1:0] rs;
    logic [11:0] inst;
    logic [3:0]  d;
    if (!reset) begin
      model_reset();
    end else if (m_active) begin
      if (m_t == m_len) begin
        m_active = 1'b0;
        m_t = 0;
      end else begin
        m_t++;
      end
    end else if (req != '0) begin
      w = -1;
      for (int i = 1; i <= NREQ; i++) begin
        rs = req >> ((m_last + i) % NREQ);
        if (w < 0 && rs[0]) w = (m_last + i) % NREQ;
      end
      inst     = req_inst[w*12 +: 12];
      m_owner  = w;
      m_last   = w;
      m_legal  = legal_op(inst[11:8]);
      m_rdo    = m_legal && inst[11:8] == `RegBankS8_RDO;
      m_len    = m_rdo ? 2 + L : 2;
      if (m_legal) m_rb_inst = inst;
      if (m_rdo) m_rdval = m_regs[inst[2:0]];
      if (m_legal && inst[11:8] >= `RegBankS8_LD0 && inst[11:8] <= `RegBankS8_LD7) begin
        d = inst[11:8] - `RegBankS8_LD0;
        m_regs[d[2:0]] = inst[7:0];
      end
      m_active = 1'b1;
      m_t = 1;
    end
  endtask

  // One clock cycle: apply pending drops, check outputs mid-cycle, advance the model.
  task automatic step();
    logic [NREQ-1:0] ack_exp;
    bit en_exp, done_cyc;
    req = req & ~drop_pend;
    drop_pend = '0;
    @(negedge clock);
    done_cyc = m_active && (m_t == m_len);
    ack_exp  = done_cyc ? (NREQ'(1) << m_owner) : '0;
    en_exp   = m_active && (m_t == 1) && m_legal;
    check_eq("busy", busy, m_active);
    check_eq("rb_inst_en", rb_inst_en, en_exp);
    check_eq("rb_inst", rb_inst, m_rb_inst);
    check_eq("ack", ack, ack_exp);
    check_eq("err", err, done_cyc && !m_legal);
    check_eq("rd_data", rd_data, (done_cyc && m_rdo) ? m_rdval : 8'h00);
    check_eq("ack_onehot0", $onehot0(ack), 1);
    if (rb_inst_en) begin
      en_ops.push_back(rb_inst[7:0]);
      en_cyc.push_back(cyc);
    end
    if (ack != '0) begin
      last_rd  = rd_data;
      last_err = err;
    end
    ack_seen  = ack_exp;
    drop_pend = ack;
    @(posedge clock);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic set_req(input int k, input logic [11:0] inst);
    req_inst[k*12 +: 12] = inst;
    req = req | (NREQ'(1) << k);
  endtask

  // Run until the model completes requester k's op, then one more cycle so the drop lands.
  task automatic wait_ack(input int k, input string tag);
    logic [NREQ-1:0] s;
    bit got;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      step();
      s = ack_seen >> k;
      got = s[0];
    end
    check_eq(tag, got, 1);
    step();
  endtask

  function automatic logic [11:0] rand_inst();
    logic [3:0] op;
    if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(10, 15));
    else                           op = 4'($urandom_range(0, 9));
    return {op, 8'($urandom_range(0, 255))};
  endfunction

  initial begin
    int cnt0, cnt1;
    logic [NREQ-1:0] s;
    model_reset();
    @(posedge clock);
    #1;
    // reset held for two cycles
    step();
    step();
    reset = 1'b1;

    // both request at once: requester 0 wins first
    en_ops.delete();
    set_req(0, {`RegBankS8_LD0 + 4'd3, 8'h5A});
    set_req(1, {`RegBankS8_LD0, 8'hC4});
    wait_ack(0, "t1_ack0");
    check_eq("t1_first_grant", en_ops.size() > 0 ? en_ops[0] : 8'hxx, 8'h5A);
    wait_ack(1, "t1_ack1");

    // read back register 3
    set_req(0, {`RegBankS8_RDO, 8'h03});
    wait_ack(0, "t2_ack");
    check_eq("t2_rd", last_rd, 8'h5A);

    // both requesting continuously: grants alternate, starting after last=0
    en_ops.delete();
    en_cyc.delete();
    cnt0 = 1;
    cnt1 = 1;
    set_req(0, {`RegBankS8_LD0, 8'h20});
    set_req(1, {`RegBankS8_LD0, 8'h30});
    for (int n = 0; n < 80; n++) begin
      if (cnt0 == 4 && cnt1 == 4 && req == '0 && !m_active) break;
      step();
      s = req;
      if (!s[0] && cnt0 < 4) begin set_req(0, {`RegBankS8_LD0, 8'h20 + 8'(cnt0)}); cnt0++; end
      if (!s[1] && cnt1 < 4) begin set_req(1, {`RegBankS8_LD0, 8'h30 + 8'(cnt1)}); cnt1++; end
    end
    check_eq("t3_count", en_ops.size(), 8);
    for (int i = 0; i < en_ops.size(); i++)
      check_eq("t3_order", en_ops[i], (i % 2 == 0) ? 8'h30 + 8'(i / 2) : 8'h20 + 8'(i / 2));
    for (int i = 0; i + 1 < en_cyc.size(); i++)
      check_eq("t3_spacing", en_cyc[i+1] - en_cyc[i], 3);

    // illegal opcode is rejected and never reaches the bank
    en_ops.delete();
    set_req(1, 12'hFAB);
    wait_ack(1, "t4_ack");
    check_eq("t4_err", last_err, 1);
    check_eq("t4_no_issue", en_ops.size(), 0);
    set_req(1, {`RegBankS8_RDO, 8'h03});
    wait_ack(1, "t4_rd_ack");
    check_eq("t4_rd", last_rd, 8'h5A);

    // reset during the WAIT of a read, with requester 1 also pending
    set_req(0, {`RegBankS8_RDO, 8'h08});
    step();
    set_req(1, {`RegBankS8_LD0 + 4'd1, 8'h77});
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    en_ops.delete();
    wait_ack(0, "t5_ack0");
    check_eq("t5_regrant", en_ops.size() > 0 ? en_ops[0] : 8'hxx, 8'h08);
    check_eq("t5_rd", last_rd, 8'h23);
    wait_ack(1, "t5_ack1");

    // request pulsed only for the grant cycle still completes
    set_req(0, {`RegBankS8_LD7, 8'h61});
    step();
    req = req & ~NREQ'(1);
    wait_ack(0, "t6_ack");
    set_req(0, {`RegBankS8_RDO, 8'h07});
    wait_ack(0, "t6_rd_ack");
    check_eq("t6_rd", last_rd, 8'h61);

    // random traffic, early drops and occasional resets
    for (int n = 0; n < 700; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        s = req >> k;
        if (!s[0] && !(m_active && m_owner == k) && $urandom_range(0, 3) == 0)
          set_req(k, rand_inst());
        else if (s[0] && m_active && m_owner == k && m_t == 1 && $urandom_range(0, 3) == 0)
          req = req & ~(NREQ'(1) << k);
      end
      reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset = 1'b1;
    req = '0;
    for (int n = 0; n < 12; n++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
